// File: rtl/bit_serial_add_ctrl.sv
`timescale 1ns/1ps
// bit_serial_add_ctrl: adds two WIDTH-bit operands LSB first through one
// shared single-bit full-adder cell, with valid/ready handshakes on the
// operand side and the result side.
// Optional macro BIT_SERIAL_SUB_EN adds a 'sub' input that turns the
// operation into A - B (C_out = 1 means no borrow).

// Single-bit full-adder cell that is time-shared across all bit positions.
module bit_serial_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));
endmodule

module bit_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
`ifdef BIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_fa_s;
    logic             w_fa_co;

    // Operand B and the initial carry as captured on the accepting edge;
    // subtraction is A + ~B + 1.
`ifdef BIT_SERIAL_SUB_EN
    assign w_b_load = sub ? ~B : B;
    assign w_c_load = sub ? 1'b1 : C_in;
`else
    assign w_b_load = B;
    assign w_c_load = C_in;
`endif

    bit_serial_fa u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .c  (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // Control FSM plus datapath registers; all outputs are registered so
    // there is no combinational path from in_valid or out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= A;
                        r_b        <= w_b_load;
                        r_carry    <= w_c_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        // Publish the finished result; S/C_out then hold it
                        // until the next operation completes.
                        r_s         <= {w_fa_s, r_res[WIDTH-1:1]};
                        r_cout      <= w_fa_co;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign S         = r_s;
    assign C_out     = r_cout;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for bit_serial_add_ctrl (WIDTH=16). Expected results
// come from plain wide-integer arithmetic on the operands.
module tb_bit_serial_add_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         C_out;
    logic         busy;
`ifdef BIT_SERIAL_SUB_EN
    logic         sub;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C_in      (C_in),
`ifdef BIT_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C_out     (C_out),
        .busy      (busy)
    );

    // Reference: {C_out,S} = A + B + C_in, or A - B as A + ~B + 1.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
        logic [W-1:0] nb;
        nb = ~b;
        if (sb) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Drives one operation and reports what the DUT produced; the caller checks.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sb, input int hold,
                         output logic [W-1:0] s, output logic co, output int lat,
                         output bit ok, output logic [W:0] exp_v);
        bit rdy;
        bit seen;
        exp_v = model(a, b, cin, sb);
        wait_ready(rdy);
        A = a; B = b; C_in = cin;
`ifdef BIT_SERIAL_SUB_EN
        sub = sb;
`endif
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        ok = rdy & seen;
        s  = S;
        co = C_out;
        $display("op A=%h B=%h cin=%0d sub=%0d -> S=%h C_out=%0d latency=%0d (expect S=%h C_out=%0d)",
                 a, b, cin, sb, s, co, lat, exp_v[W-1:0], exp_v[W]);
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; C_in = 1'b0;
        repeat (3) tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (S !== '0) begin n_fail++; $display("FAIL reset_S got=%h want=0000", S); end
        n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL reset_C_out got=%b want=0", C_out); end
        rst_n = 1'b1;
        tick();
        $display("reset checked");
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{16'h00FF, 16'hFFFF, 16'h1234};
        logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h4321};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{16'h0100, 16'h0000, 16'h5556};
        logic         ec [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] s; logic co; int lat; bit ok; logic [W:0] ev;
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], vc[k], 1'b0, k, s, co, lat, ok, ev);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL directed_timeout[%0d] got=no_out_valid want=out_valid", k); end
            n_cmp++; if (s !== es[k]) begin n_fail++; $display("FAIL directed_S[%0d] got=%h want=%h", k, s, es[k]); end
            n_cmp++; if (co !== ec[k]) begin n_fail++; $display("FAIL directed_C_out[%0d] got=%b want=%b", k, co, ec[k]); end
            n_cmp++; if (lat !== W) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", k, lat, W); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s; logic cin, co, sb; int lat; bit ok; logic [W:0] ev;
        for (int k = 0; k < 24; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
`ifdef BIT_SERIAL_SUB_EN
            sb  = 1'($urandom);
`else
            sb  = 1'b0;
`endif
            repeat ($urandom_range(0, 2)) tick();
            do_op(a, b, cin, sb, $urandom_range(0, 3), s, co, lat, ok, ev);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL random_timeout[%0d] got=no_out_valid want=out_valid", k); end
            n_cmp++; if ({co, s} !== ev) begin n_fail++; $display("FAIL random_sum[%0d] got=%0d_%h want=%0d_%h", k, co, s, ev[W], ev[W-1:0]); end
            n_cmp++; if (lat !== W) begin n_fail++; $display("FAIL random_latency[%0d] got=%0d want=%0d", k, lat, W); end
        end
    endtask

    task automatic test_backpressure();
        bit rdy; bit seen; int bad;
        logic [W-1:0] s; logic co; int lat; bit ok; logic [W:0] ev;
        wait_ready(rdy);
        A = 16'hAAAA; B = 16'h5555; C_in = 1'b0;
`ifdef BIT_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        // Operand pulses during RUN must be ignored.
        seen = 1'b0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            if (in_ready !== 1'b0) bad++;
            in_valid = 1'($urandom);
            A = W'($urandom); B = W'($urandom); C_in = 1'($urandom);
            tick();
        end
        n_cmp++; if (!(rdy && seen)) begin n_fail++; $display("FAIL bp_timeout got=no_out_valid want=out_valid"); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_run_in_ready got=%0d_high_cycles want=0", bad); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; A = W'($urandom); B = W'($urandom);
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (S !== 16'hFFFF) begin n_fail++; $display("FAIL bp_S[%0d] got=%h want=ffff", i, S); end
            n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL bp_C_out[%0d] got=%b want=0", i, C_out); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("backpressure handshake done S held through 10 stall cycles");
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_after got=%b want=0", out_valid); end
        do_op(16'h0102, 16'h0304, 1'b0, 1'b0, 0, s, co, lat, ok, ev);
        n_cmp++; if ({co, s} !== ev) begin n_fail++; $display("FAIL bp_followup got=%0d_%h want=%0d_%h", co, s, ev[W], ev[W-1:0]); end
    endtask

    task automatic test_reset_midrun();
        bit rdy; logic [W-1:0] s; logic co; int lat; bit ok; logic [W:0] ev;
        wait_ready(rdy);
        A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b0;
`ifdef BIT_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        n_cmp++; if (busy !== 1'b1 || !rdy) begin n_fail++; $display("FAIL midrun_busy got=%b want=1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrun_in_ready got=%b want=0", in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("reset asserted on 7th RUN cycle");
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (S !== '0) begin n_fail++; $display("FAIL rst_mid_S got=%h want=0000", S); end
        n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_C_out got=%b want=0", C_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, s, co, lat, ok, ev);
        n_cmp++; if (s !== 16'h0007 || co !== 1'b0 || !ok) begin n_fail++; $display("FAIL rst_mid_fresh got=%0d_%h want=0_0007", co, s); end
        n_cmp++; if (lat !== W) begin n_fail++; $display("FAIL rst_mid_latency got=%0d want=%0d", lat, W); end
    endtask

    task automatic test_back_to_back();
        bit rdy; int cyc; int nacc; int nres; bit acc; bit res;
        int acc_cyc [2];
        logic [W-1:0] rs [2];
        logic         rc [2];
        wait_ready(rdy);
        A = 16'h0001; B = 16'h0001; C_in = 1'b0;
`ifdef BIT_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; nacc = 0; nres = 0;
        acc_cyc = '{0, 0}; rs = '{16'h0, 16'h0}; rc = '{1'b0, 1'b0};
        for (int i = 0; i < 80; i++) begin
            acc = in_valid && in_ready;
            res = out_valid && out_ready;
            if (res && nres < 2) begin
                rs[nres] = S; rc[nres] = C_out;
                $display("b2b result %0d S=%h C_out=%0d at cycle %0d", nres, S, C_out, cyc);
                nres++;
            end
            if (nres == 2) break;
            tick();
            cyc++;
            if (acc && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin A = 16'h8000; B = 16'h8000; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        n_cmp++; if (nacc !== 2 || nres !== 2 || !rdy) begin n_fail++; $display("FAIL b2b_count got=%0d_acc_%0d_res want=2_acc_2_res", nacc, nres); end
        n_cmp++; if (rs[0] !== 16'h0002 || rc[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_first got=%0d_%h want=0_0002", rc[0], rs[0]); end
        n_cmp++; if (rs[1] !== 16'h0000 || rc[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_second got=%0d_%h want=1_0000", rc[1], rs[1]); end
        n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== W + 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=%0d", acc_cyc[1] - acc_cyc[0], W + 2); end
    endtask

`ifdef BIT_SERIAL_SUB_EN
    task automatic test_sub();
        logic [W-1:0] s; logic co; int lat; bit ok; logic [W:0] ev;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, s, co, lat, ok, ev);
        n_cmp++; if (s !== 16'hFFFE || co !== 1'b0 || !ok) begin n_fail++; $display("FAIL sub_5_7 got=%0d_%h want=0_fffe", co, s); end
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, s, co, lat, ok, ev);
        n_cmp++; if (s !== 16'h0002 || co !== 1'b1 || !ok) begin n_fail++; $display("FAIL sub_7_5 got=%0d_%h want=1_0002", co, s); end
        do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 0, s, co, lat, ok, ev);
        n_cmp++; if (s !== 16'h000D || co !== 1'b0 || !ok) begin n_fail++; $display("FAIL sub_off_add got=%0d_%h want=0_000d", co, s); end
    endtask
`endif

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        A = '0; B = '0; C_in = 1'b0;
`ifdef BIT_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
`ifdef BIT_SERIAL_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
